// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialization sequencer: walks the JEDEC init command list on the
// shared CA bus, then parks on NOP with init_done set.
`ifndef DDR_BA_WIDTH
`define DDR_BA_WIDTH 3
`endif
`ifndef DDR_ADDR_WIDTH
`define DDR_ADDR_WIDTH 14
`endif
`ifndef CAS_LATENCY
`define CAS_LATENCY 5
`endif

module ddr2_init_seq #(
  parameter int BA_WIDTH   = `DDR_BA_WIDTH,
  parameter int ADDR_WIDTH = `DDR_ADDR_WIDTH,
  parameter int CL         = `CAS_LATENCY,
  parameter int T_PWRUP    = 200,
  parameter int T_CKE      = 40,
  parameter int T_RP       = 4,
  parameter int T_MRD      = 2,
  parameter int T_RFC      = 26,
  parameter int T_DLLK     = 200,
  parameter logic [ADDR_WIDTH-1:0] EMR1_BASE = 'h400
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  cke,
  output logic                  cs_n,
  output logic                  ras_n,
  output logic                  cas_n,
  output logic                  we_n,
  output logic [BA_WIDTH-1:0]   ba,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  odt,
  output logic                  init_done,
  output logic                  busy
);

  function automatic int max_slot();
    int m;
    m = 1;
    if (T_PWRUP > m) m = T_PWRUP;
    if (T_CKE > m)   m = T_CKE;
    if (T_RP > m)    m = T_RP;
    if (T_MRD > m)   m = T_MRD;
    if (T_RFC > m)   m = T_RFC;
    if (T_DLLK > m)  m = T_DLLK;
    return m;
  endfunction

  localparam int CNT_W = $clog2(max_slot() + 1);

  // MR: BL4, sequential burst, CAS latency CL, write recovery 6 (encoded as 5)
  localparam logic [ADDR_WIDTH-1:0] MR_VAL  = ADDR_WIDTH'((5 << 9) | ((CL & 7) << 4) | 2);
  localparam logic [ADDR_WIDTH-1:0] A10     = ADDR_WIDTH'(1 << 10);
  localparam logic [ADDR_WIDTH-1:0] DLL_RST = ADDR_WIDTH'('h100);
  localparam logic [ADDR_WIDTH-1:0] OCD_DEF = ADDR_WIDTH'('h380);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_DES = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  // S_RESET is the held-in-reset state; the first edge after release enters S_PWRUP
  localparam logic [3:0] S_RESET      = 4'd0;
  localparam logic [3:0] S_PWRUP      = 4'd1;
  localparam logic [3:0] S_CKE        = 4'd2;
  localparam logic [3:0] S_PRE1       = 4'd3;
  localparam logic [3:0] S_EMRS2      = 4'd4;
  localparam logic [3:0] S_EMRS3      = 4'd5;
  localparam logic [3:0] S_EMRS1      = 4'd6;
  localparam logic [3:0] S_MRS_DLL    = 4'd7;
  localparam logic [3:0] S_PRE2       = 4'd8;
  localparam logic [3:0] S_REF1       = 4'd9;
  localparam logic [3:0] S_REF2       = 4'd10;
  localparam logic [3:0] S_MRS        = 4'd11;
  localparam logic [3:0] S_EMRS1_OCD  = 4'd12;
  localparam logic [3:0] S_EMRS1_EXIT = 4'd13;
  localparam logic [3:0] S_DLLK       = 4'd14;
  localparam logic [3:0] S_DONE       = 4'd15;

  function automatic logic [CNT_W-1:0] slot_last(input int cycles);
    return (cycles < 1) ? '0 : CNT_W'(cycles - 1);
  endfunction

  logic [3:0]            state, nxt_state;
  logic [CNT_W-1:0]      cnt, nxt_cnt;
  logic                  issue;
  logic                  cke_d, odt_d, done_d, busy_d;
  logic [3:0]            cmd_d;
  logic [BA_WIDTH-1:0]   ba_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  // Sequencing: the counter holds the remaining cycles of the current slot; at zero
  // the next state is entered and the counter reloaded with that slot's length.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    issue     = 1'b0;
    if (state != S_DONE) begin
      if (cnt != '0) begin
        nxt_cnt = cnt - 1'b1;
      end else begin
        nxt_state = state + 4'd1;
        issue     = 1'b1;
        case (nxt_state)
          S_PWRUP:                nxt_cnt = slot_last(T_PWRUP);
          S_CKE:                  nxt_cnt = slot_last(T_CKE);
          S_PRE1, S_PRE2:         nxt_cnt = slot_last(T_RP);
          S_REF1, S_REF2:         nxt_cnt = slot_last(T_RFC);
          S_DLLK:                 nxt_cnt = slot_last(T_DLLK);
          S_DONE:                 nxt_cnt = '0;
          default:                nxt_cnt = slot_last(T_MRD);
        endcase
      end
    end
  end

  // Bus contents for the cycle being entered; commands only on a slot's first cycle
  always_comb begin
    cke_d  = 1'b1;
    cmd_d  = CMD_NOP;
    ba_d   = '0;
    addr_d = '0;
    odt_d  = 1'b0;
    done_d = 1'b0;
    busy_d = 1'b1;
    case (nxt_state)
      S_RESET, S_PWRUP: begin
        cke_d = 1'b0;
        cmd_d = CMD_DES;
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        if (issue) begin
          case (nxt_state)
            S_PRE1, S_PRE2: begin
              cmd_d  = CMD_PRE;
              addr_d = A10;
            end
            S_REF1, S_REF2: cmd_d = CMD_REF;
            S_EMRS2: begin
              cmd_d = CMD_MRS;
              ba_d  = BA_WIDTH'(2);
            end
            S_EMRS3: begin
              cmd_d = CMD_MRS;
              ba_d  = BA_WIDTH'(3);
            end
            S_EMRS1, S_EMRS1_EXIT: begin
              cmd_d  = CMD_MRS;
              ba_d   = BA_WIDTH'(1);
              addr_d = EMR1_BASE;
            end
            S_EMRS1_OCD: begin
              cmd_d  = CMD_MRS;
              ba_d   = BA_WIDTH'(1);
              addr_d = EMR1_BASE | OCD_DEF;
            end
            S_MRS_DLL: begin
              cmd_d  = CMD_MRS;
              addr_d = MR_VAL | DLL_RST;
            end
            S_MRS: begin
              cmd_d  = CMD_MRS;
              addr_d = MR_VAL;
            end
            default: cmd_d = CMD_NOP;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RESET;
      cnt       <= '0;
      cke       <= 1'b0;
      cs_n      <= 1'b1;
      ras_n     <= 1'b1;
      cas_n     <= 1'b1;
      we_n      <= 1'b1;
      ba        <= '0;
      addr      <= '0;
      odt       <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      cke       <= cke_d;
      {cs_n, ras_n, cas_n, we_n} <= cmd_d;
      ba        <= ba_d;
      addr      <= addr_d;
      odt       <= odt_d;
      init_done <= done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Bench for ddr2_init_seq: compares every bus cycle against a slot-list model of the
// DDR2 init sequence, for the default build and a CL=3 / T_MRD=1 build.
module tb_ddr2_init_seq;

  localparam int T_PWRUP = 200;
  localparam int T_CKE   = 40;
  localparam int T_RP    = 4;
  localparam int T_RFC   = 26;
  localparam int T_DLLK  = 200;
  localparam logic [24:0] RESET_BUS = {1'b0, 4'b1111, 3'd0, 14'd0, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic cke_a, cs_n_a, ras_n_a, cas_n_a, we_n_a, odt_a, done_a, busy_a;
  logic cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b, odt_b, done_b, busy_b;
  logic [2:0]  ba_a, ba_b;
  logic [13:0] addr_a, addr_b;
  logic [24:0] bus_a, bus_b;

  always #5 clk = ~clk;

  ddr2_init_seq dut_a (
    .clk(clk), .rst(rst_a), .cke(cke_a), .cs_n(cs_n_a), .ras_n(ras_n_a), .cas_n(cas_n_a),
    .we_n(we_n_a), .ba(ba_a), .addr(addr_a), .odt(odt_a), .init_done(done_a), .busy(busy_a)
  );

  ddr2_init_seq #(.CL(3), .T_MRD(1)) dut_b (
    .clk(clk), .rst(rst_b), .cke(cke_b), .cs_n(cs_n_b), .ras_n(ras_n_b), .cas_n(cas_n_b),
    .we_n(we_n_b), .ba(ba_b), .addr(addr_b), .odt(odt_b), .init_done(done_b), .busy(busy_b)
  );

  assign bus_a = {cke_a, cs_n_a, ras_n_a, cas_n_a, we_n_a, ba_a, addr_a, odt_a, done_a, busy_a};
  assign bus_b = {cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b, ba_b, addr_b, odt_b, done_b, busy_b};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected bus for cycle c: walk the list of command slots, accumulating start times
  function automatic logic [24:0] modelBus(input int c, input int cl, input int t_mrd);
    int          mrd, start;
    logic [13:0] mr;
    int          lens[11];
    logic [3:0]  cmds[11];
    logic [2:0]  bas[11];
    logic [13:0] addrs[11];
    mrd   = (t_mrd < 1) ? 1 : t_mrd;
    mr    = 14'(2 + cl * 16 + 5 * 512);
    lens  = '{T_RP, mrd, mrd, mrd, mrd, T_RP, T_RFC, T_RFC, mrd, mrd, mrd};
    cmds  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
              4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    bas   = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    addrs = '{14'h400, 14'h0, 14'h0, 14'h400, mr | 14'h100, 14'h400,
              14'h0, 14'h0, mr, 14'h780, 14'h400};
    if (c < T_PWRUP) return {1'b0, 4'b1111, 3'd0, 14'd0, 3'b001};
    start = T_PWRUP + T_CKE;
    for (int i = 0; i < 11; i++) begin
      if (c == start) return {1'b1, cmds[i], bas[i], addrs[i], 3'b001};
      start += lens[i];
    end
    return {1'b1, 4'b0111, 3'd0, 14'd0, 1'b0, (c >= start + T_DLLK), (c < start + T_DLLK)};
  endfunction

  function automatic int modelDone(input int t_mrd);
    return T_PWRUP + T_CKE + 2 * T_RP + 7 * t_mrd + 2 * T_RFC + T_DLLK;
  endfunction

  function automatic logic [24:0] busOf(input bit use_b);
    return use_b ? bus_b : bus_a;
  endfunction

  task automatic setRst(input bit use_b, input logic v);
    if (use_b) rst_b = v;
    else rst_a = v;
  endtask

  // Release reset, compare each cycle; optionally slam reset asynchronously mid-cycle
  task automatic applyStimulus(input bit use_b, input int run_cycles, input int abort_cycle);
    int          cl, mrd, cmd_count, done_at;
    bit          aborted;
    logic [24:0] got;
    cl = use_b ? 3 : 5;
    mrd = use_b ? 1 : 2;
    cmd_count = 0;
    done_at = -1;
    aborted = 0;
    @(negedge clk);
    setRst(use_b, 1'b0);
    for (int c = 0; c < run_cycles; c++) begin
      @(posedge clk);
      if (c == abort_cycle) begin
        #(1 + $urandom_range(0, 2));
        setRst(use_b, 1'b1);
        #1;
        checkOutput($sformatf("abort_reset@%0d", c), 32'(busOf(use_b)), 32'(RESET_BUS));
        aborted = 1;
        break;
      end
      @(negedge clk);
      got = busOf(use_b);
      checkOutput($sformatf("bus%s@%0d", use_b ? "_b" : "_a", c), 32'(got), 32'(modelBus(c, cl, mrd)));
      if (got[23:20] != 4'b0111 && got[23:20] != 4'b1111) cmd_count++;
      if (got[1] && done_at < 0) done_at = c;
    end
    if (!aborted) begin
      checkOutput("cmd_count", 32'(cmd_count), 32'd11);
      checkOutput("done_cycle", 32'(done_at), 32'(modelDone(mrd)));
      @(negedge clk);
      setRst(use_b, 1'b1);
      #1;
      checkOutput("reset_async", 32'(busOf(use_b)), 32'(RESET_BUS));
    end
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_a", 32'(bus_a), 32'(RESET_BUS));
    checkOutput("reset_b", 32'(bus_b), 32'(RESET_BUS));
    applyStimulus(1'b0, modelDone(2) + 100, -1);
    applyStimulus(1'b0, modelDone(2) + 100, 260);
    applyStimulus(1'b0, modelDone(2) + 100, -1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, modelDone(2) + 100, int'($urandom_range(1, 600)));
    end
    applyStimulus(1'b0, modelDone(2) + 100, -1);
    applyStimulus(1'b1, modelDone(1) + 100, -1);
    applyStimulus(1'b1, modelDone(1) + 100, int'($urandom_range(1, 500)));
    applyStimulus(1'b1, modelDone(1) + 100, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
